// File: rtl/poke_entry.sv
// Switch/push-key hex entry: assembles a 32-bit word and pokes it into the register file or memory.
// Optional POKE_AUTOINC_EN: bump addrReg by 4 after each acknowledged memory poke.
module poke_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACK_TIMEOUT     = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        keyN,
  input  logic [9:0]  switches,
  output logic [31:0] entryData,
  output logic [3:0]  nibbleCount,
  output logic [31:0] addrReg,
  output logic        regWrEn,
  output logic [4:0]  regWrAddr,
  output logic [31:0] regWrData,
  output logic        memWrReq,
  output logic [31:0] memWrAddr,
  output logic [31:0] memWrData,
  input  logic        memWrAck,
  output logic        busy,
  output logic        pokeErr
);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, EXEC, MEM_REQ, RELEASE} state_t;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [1:0]  key_sync;
  logic        key_s;
  logic [15:0] cnt;
  logic [1:0]  cmd_op;
  logic        cmd_clr;
  logic [4:0]  cmd_idx;
  logic        unused_sw;

  assign key_s     = key_sync[1];
  assign busy      = (state != IDLE);
  assign unused_sw = ^switches[6:5];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      key_sync    <= 2'b11;
      cnt         <= '0;
      cmd_op      <= '0;
      cmd_clr     <= 1'b0;
      cmd_idx     <= '0;
      entryData   <= '0;
      nibbleCount <= '0;
      addrReg     <= '0;
      regWrEn     <= 1'b0;
      regWrAddr   <= '0;
      regWrData   <= '0;
      memWrReq    <= 1'b0;
      memWrAddr   <= '0;
      memWrData   <= '0;
      pokeErr     <= 1'b0;
    end else begin
      key_sync <= {key_sync[0], keyN};
      regWrEn  <= 1'b0;
      case (state)
        IDLE: begin
          // cnt counts low samples seen, including this first one
          if (!key_s) begin
            if (DB_LAST == 16'd0) begin
              cmd_op  <= switches[9:8];
              cmd_clr <= switches[7];
              cmd_idx <= switches[4:0];
              pokeErr <= 1'b0;
              state   <= EXEC;
            end else begin
              cnt   <= 16'd1;
              state <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (key_s) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            cmd_op  <= switches[9:8];
            cmd_clr <= switches[7];
            cmd_idx <= switches[4:0];
            pokeErr <= 1'b0;
            state   <= EXEC;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        EXEC: begin
          cnt   <= '0;
          state <= RELEASE;
          case (cmd_op)
            2'b00: begin
              if (cmd_clr) begin
                entryData   <= '0;
                nibbleCount <= '0;
              end else begin
                entryData <= {entryData[27:0], cmd_idx[3:0]};
                if (nibbleCount != 4'd8) nibbleCount <= nibbleCount + 4'd1;
              end
            end
            2'b01: addrReg <= entryData;
            2'b10: begin
              regWrEn   <= 1'b1;
              regWrAddr <= cmd_idx;
              regWrData <= entryData;
            end
            default: begin
              memWrReq  <= 1'b1;
              memWrAddr <= addrReg;
              memWrData <= entryData;
              state     <= MEM_REQ;
            end
          endcase
        end
        MEM_REQ: begin
          // ack is checked first so an ack on the final timeout cycle still succeeds
          if (memWrAck) begin
            memWrReq <= 1'b0;
            cnt      <= '0;
            state    <= RELEASE;
`ifdef POKE_AUTOINC_EN
            addrReg  <= addrReg + 32'd4;
`endif
          end else if (cnt == TO_LAST) begin
            memWrReq <= 1'b0;
            pokeErr  <= 1'b1;
            cnt      <= '0;
            state    <= RELEASE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RELEASE: begin
          if (!key_s)              cnt   <= '0;
          else if (cnt == DB_LAST) state <= IDLE;
          else                     cnt   <= cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poke_entry.sv
// Directed bench for poke_entry: nibble entry, clear, address latch, register and memory pokes, timeout, reset.
module tb_poke_entry;

  localparam int DB = 4;
  localparam int TO = 6;
`ifdef POKE_AUTOINC_EN
  localparam logic [31:0] ADDR_AFTER = 32'h14;
`else
  localparam logic [31:0] ADDR_AFTER = 32'h10;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        keyN = 1'b1;
  logic [9:0]  switches = '0;
  logic [31:0] entryData;
  logic [3:0]  nibbleCount;
  logic [31:0] addrReg;
  logic        regWrEn;
  logic [4:0]  regWrAddr;
  logic [31:0] regWrData;
  logic        memWrReq;
  logic [31:0] memWrAddr;
  logic [31:0] memWrData;
  logic        memWrAck = 1'b0;
  logic        busy;
  logic        pokeErr;

  int checks = 0;
  int errors = 0;

  logic        ack_en = 1'b1;
  int          req_cyc = 0;
  int          we_cnt = 0, req_win = 0, req_hi = 0;
  logic        prev_req = 1'b0;
  logic [4:0]  cap_wa;
  logic [31:0] cap_wd, cap_ma, cap_md;

  poke_entry #(.DEBOUNCE_CYCLES(DB), .ACK_TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .keyN(keyN), .switches(switches),
    .entryData(entryData), .nibbleCount(nibbleCount), .addrReg(addrReg),
    .regWrEn(regWrEn), .regWrAddr(regWrAddr), .regWrData(regWrData),
    .memWrReq(memWrReq), .memWrAddr(memWrAddr), .memWrData(memWrData),
    .memWrAck(memWrAck), .busy(busy), .pokeErr(pokeErr)
  );

  always #5 Clk = ~Clk;

  // memory responder: ack on the third cycle of a request window
  always @(negedge Clk) begin
    if (memWrReq) begin
      req_cyc  = req_cyc + 1;
      memWrAck = ack_en && (req_cyc == 3);
    end else begin
      req_cyc  = 0;
      memWrAck = 1'b0;
    end
  end

  always @(negedge Clk) begin
    if (regWrEn) begin
      we_cnt = we_cnt + 1;
      cap_wa = regWrAddr;
      cap_wd = regWrData;
    end
    if (memWrReq) req_hi = req_hi + 1;
    if (memWrReq && !prev_req) begin
      req_win = req_win + 1;
      cap_ma  = memWrAddr;
      cap_md  = memWrData;
    end
    prev_req = memWrReq;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [9:0] sw, input int hold);
    bit done = 0;
    switches = sw;
    @(negedge Clk);
    keyN = 1'b0;
    repeat (hold) @(negedge Clk);
    keyN = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge Clk);
      if (!busy) done = 1;
    end
    check("idle_wait", 32'(done), 32'd1);
    repeat (2) @(negedge Clk);
  endtask

  task automatic nib(input logic [3:0] n);
    press({6'b000000, n}, 12);
  endtask

  task automatic clr();
    press(10'b00_1_0000000, 12);
  endtask

  initial begin
    int w0, r0, h0;
    logic [31:0] ed;
    bit seen;

    repeat (3) @(negedge Clk);
    check("rst_entry", entryData, 32'h0);
    check("rst_count", 32'(nibbleCount), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(memWrReq), 32'd0);
    check("rst_addr", addrReg, 32'h0);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);

    for (int n = 1; n <= 9; n++) nib(4'(n));
    check("nib9_data", entryData, 32'h23456789);
    check("nib9_count", 32'(nibbleCount), 32'd8);

    clr();
    check("clr_data", entryData, 32'h0);
    check("clr_count", 32'(nibbleCount), 32'd0);

    nib(4'h1); nib(4'h0);
    check("addr_entry", entryData, 32'h10);
    press(10'b01_0000_0000, 12);
    check("addr_latch", addrReg, 32'h10);

    clr();
    for (int n = 0; n < 8; n++) nib(4'h3);
    r0 = req_win; h0 = req_hi;
    press(10'b11_0000_0000, 12);
    check("mem_windows", 32'(req_win - r0), 32'd1);
    check("mem_req_len", 32'(req_hi - h0), 32'd3);
    check("mem_addr", cap_ma, 32'h10);
    check("mem_data", cap_md, 32'h33333333);
    check("mem_err", 32'(pokeErr), 32'd0);
    check("mem_addr_after", addrReg, ADDR_AFTER);

    clr();
    for (int n = 0; n < 8; n++) nib(4'h9);
    w0 = we_cnt;
    press(10'b10_000_00101, 12);
    check("reg_pulses", 32'(we_cnt - w0), 32'd1);
    check("reg_addr", 32'(cap_wa), 32'd5);
    check("reg_data", cap_wd, 32'h99999999);

    ed = entryData;
    press(10'b00_0000_1010, DB - 2);
    check("glitch_data", entryData, ed);

    press(10'b00_0000_1011, 200);
    check("hold_data", entryData, 32'h9999999B);
    check("hold_count", 32'(nibbleCount), 32'd8);

    ack_en = 1'b0;
    r0 = req_win; h0 = req_hi;
    press(10'b11_0000_0000, 12);
    check("to_windows", 32'(req_win - r0), 32'd1);
    check("to_req_len", 32'(req_hi - h0), 32'(TO));
    check("to_err", 32'(pokeErr), 32'd1);
    check("to_addr", addrReg, ADDR_AFTER);
    nib(4'hC);
    check("err_cleared", 32'(pokeErr), 32'd0);

    switches = 10'b11_0000_0000;
    @(negedge Clk);
    keyN = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge Clk);
      if (memWrReq) seen = 1;
    end
    check("rst_req_seen", 32'(seen), 32'd1);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("midrst_req", 32'(memWrReq), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_entry", entryData, 32'h0);
    check("midrst_addr", addrReg, 32'h0);
    @(negedge Clk);
    keyN = 1'b1;
    Rst = 1'b1;
    repeat (5) @(negedge Clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_req", 32'(memWrReq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poke_entry.md
Name: poke_entry

Overview:
- User-input counterpart of the seven-segment display/peek path: the display reads register-file and memory contents out to the user; this block writes user-entered values back in.
- A 32-bit word is assembled one hex nibble at a time from the board switches. A debounced push-key commits each command.
- Each command loads a nibble, clears the buffer, latches a target address, pokes a register-file entry, or pokes a memory word over a req/ack handshake.
- Sits beside the display block between the board I/O and the processor datapath debug ports.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles the synchronized key must stay low before a press is accepted (1..65535)
ACK_TIMEOUT, 64, cycles to wait for memWrAck before aborting a memory poke (1..65535)

Ports:
Clk  input  1  system clock, all state on rising edge
Rst  input  1  asynchronous active-low reset
keyN  input  1  raw push-key, active-low, asynchronous to Clk
switches  input  10  [9:8] command, [7] clear qualifier, [4:0] register index, [3:0] nibble
entryData  output  32  nibble-assembly buffer; feeds the display
nibbleCount  output  4  nibbles entered since last clear, saturates at 8
addrReg  output  32  latched memory target address
regWrEn  output  1  one-cycle register-file write strobe
regWrAddr  output  5  register index for regWrEn
regWrData  output  32  register write data
memWrReq  output  1  memory write request, held until ack or timeout
memWrAddr  output  32  memory write address
memWrData  output  32  memory write data
memWrAck  input  1  memory write acknowledge, sampled while memWrReq=1
busy  output  1  high in any state other than IDLE
pokeErr  output  1  sticky memory-timeout flag

Behaviour:
- Reset (Rst=0, immediate, also mid-handshake): all outputs 0, counters 0, FSM in IDLE, synchronizer flops 1 (key released).
- keyN passes a 2-flop synchronizer before any use; the raw pin is never read directly.
- FSM states and transitions:
  - IDLE: synchronized key low -> DEBOUNCE, counter=1.
  - DEBOUNCE: key low increments counter; key high returns to IDLE (glitch rejected). Counter reaching DEBOUNCE_CYCLES samples switches[9:7] and switches[4:0] into a command latch -> EXEC.
  - EXEC, one cycle, dispatch on the latched command:
    - 00 with bit7=0: entryData<={entryData[27:0],nib}; nibbleCount=min(count+1,8). Older nibbles shift out of bit 31 with no error.
    - 00 with bit7=1: entryData=0, nibbleCount=0.
    - 01: addrReg<=entryData.
    - 10: regWrEn=1 for exactly this cycle, regWrAddr=index, regWrData=entryData. A write to index 0 is still issued.
    - 11: -> MEM_REQ.
    - Every path except 11 -> RELEASE.
  - MEM_REQ: memWrReq=1, memWrAddr=addrReg, memWrData=entryData, all held stable.
    - memWrAck=1 sampled: memWrReq drops next cycle -> RELEASE.
    - After ACK_TIMEOUT cycles with no ack: memWrReq drops, pokeErr=1 -> RELEASE.
    - Ack arriving on the timeout cycle counts as success.
  - RELEASE: waits until the synchronized key has been high for DEBOUNCE_CYCLES consecutive cycles -> IDLE. One physical press therefore executes exactly one command.
- Any accepted command (entry to EXEC) clears pokeErr.
- Key held indefinitely: no repeat.
- Switch changes after sampling have no effect on the command in flight.
- memWrAck outside MEM_REQ is ignored.
- Latency: key low at the pin -> EXEC = 2 sync cycles + DEBOUNCE_CYCLES cycles.
- busy is combinational from the state register.

Optional Feature:
- POKE_AUTOINC_EN defined: after a memory poke completes with ack, addrReg<=addrReg+4, wrapping modulo 2^32 (32'hFFFFFFFC -> 0). No increment on timeout.
- POKE_AUTOINC_EN undefined: addrReg changes only via command 01.

Test Plan:
- Rst low mid-MEM_REQ -> memWrReq, busy, entryData, addrReg all 0 in the same cycle; FSM IDLE after release.
- Key-press sequence:
  - Nibbles 1,2,3,4,5,6,7,8,9 -> entryData=32'h23456789, nibbleCount=8.
  - Then clear -> 0/0.
- Enter 32'h00000010, cmd 01, enter 32'h33333333, cmd 11, ack after 3 cycles -> one req window, memWrAddr=32'h10, memWrData=32'h33333333, pokeErr=0.
  - With POKE_AUTOINC_EN defined: addrReg=32'h14 afterwards.
- Enter 32'h99999999, cmd 10 with index 5 -> single-cycle regWrEn, regWrAddr=5, regWrData=32'h99999999.
- keyN low for DEBOUNCE_CYCLES-2 cycles, then a glitch high -> no command.
  - Held 200 cycles -> exactly one nibble shifted.
- Cmd 11 with memWrAck tied 0 -> memWrReq high exactly ACK_TIMEOUT cycles, pokeErr=1; next accepted press clears it.
